// File: rtl/rv32i_alu_issue.sv
// ID/EX issue stage: resolves forwarded operands, detects load-use hazards and
// registers the ALU operation. Define ISSUE_PERF_EN to build the issue/stall counters.
module rv32i_alu_issue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_alu_op,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_we,
    input  logic            id_use_pc,
    input  logic            id_use_imm,
    input  logic            id_is_load,
    input  logic            id_is_store,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            mem_fwd_valid,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [4:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stalls
);

    // The EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf,
        input logic            mv,
        input logic [4:0]      mrd,
        input logic [XLEN-1:0] mdata,
        input logic            wv,
        input logic [4:0]      wrd,
        input logic [XLEN-1:0] wdata
    );
        if (rs == 5'd0) begin
            return '0;
        end else if (mv && mrd == rs) begin
            return mdata;
        end else if (wv && wrd == rs) begin
            return wdata;
        end
        return rf;
    endfunction

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            hazard;
    logic            advance;
    logic            issue;

    always_comb begin
        rs1_val = fwd(id_rs1, rf_rs1_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                      wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        rs2_val = fwd(id_rs2, rf_rs2_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                      wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        op_a    = id_use_pc ? id_pc : rs1_val;
        op_b    = id_use_imm ? id_imm : rs2_val;
        // Stores read rs2 as data even when B is the immediate.
        hazard  = ex_valid && ex_is_load && ex_rd_we && (ex_rd != 5'd0) &&
                  ((!id_use_pc && id_rs1 == ex_rd) ||
                   ((!id_use_imm || id_is_store) && id_rs2 == ex_rd));
        advance  = !ex_valid || ex_ready;
        id_ready = rst_n && (flush || (advance && !hazard));
        issue    = advance && id_valid && !hazard;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_alu_op   <= 5'd0;
            ex_alu_a    <= '0;
            ex_alu_b    <= '0;
            ex_rs2_data <= '0;
            ex_rd       <= 5'd0;
            ex_rd_we    <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_pc       <= RESET_PC;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            if (issue) begin
                ex_valid    <= 1'b1;
                ex_alu_op   <= id_alu_op;
                ex_alu_a    <= op_a;
                ex_alu_b    <= op_b;
                ex_rs2_data <= rs2_val;
                ex_rd       <= id_rd;
                ex_rd_we    <= id_rd_we;
                ex_is_load  <= id_is_load;
                ex_is_store <= id_is_store;
                ex_pc       <= id_pc;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

`ifdef ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued <= 32'd0;
            perf_stalls <= 32'd0;
        end else begin
            if (issue && !flush) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (id_valid && !id_ready && !flush) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`else
    assign perf_issued = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Directed bench for rv32i_alu_issue: a transaction-level model of the issue slot is
// compared every cycle, and literal expectations pin the model at key points.
module tb_rv32i_alu_issue;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [4:0]  id_alu_op, id_rs1, id_rs2, id_rd;
    logic        id_rd_we, id_use_pc, id_use_imm, id_is_load, id_is_store;
    logic [31:0] id_imm, id_pc, rf_rs1_data, rf_rs2_data;
    logic        mem_fwd_valid, wb_fwd_valid;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_ready, flush;
    logic        ex_valid, ex_rd_we, ex_is_load, ex_is_store;
    logic [4:0]  ex_alu_op, ex_rd;
    logic [31:0] ex_alu_a, ex_alu_b, ex_rs2_data, ex_pc, perf_issued, perf_stalls;

    int n_vec = 0;
    int n_bad = 0;
    bit started = 1'b0;

    rv32i_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
        .id_is_load(id_is_load), .id_is_store(id_is_store), .id_imm(id_imm), .id_pc(id_pc),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_pc(ex_pc), .perf_issued(perf_issued), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the issue slot: one record of what execute currently holds.
    logic        m_valid, m_rd_we, m_ld, m_st;
    logic [4:0]  m_op, m_rd;
    logic [31:0] m_a, m_b, m_rs2, m_pc, m_issued, m_stalls;

    function automatic logic [31:0] value_of(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == rs) return wb_fwd_data;
        return rf;
    endfunction

    // Stall when the held load's result is actually consumed by the incoming instruction.
    function automatic bit must_wait();
        bit reads_a, reads_b;
        if (!(m_valid && m_ld && m_rd_we) || m_rd == 0) return 1'b0;
        reads_a = !id_use_pc && id_rs1 == m_rd;
        reads_b = (!id_use_imm || id_is_store) && id_rs2 == m_rd;
        return reads_a || reads_b;
    endfunction

    function automatic bit model_ready();
        if (!rst_n) return 1'b0;
        if (flush) return 1'b1;
        return (!m_valid || ex_ready) && !must_wait();
    endfunction

    always @(posedge clk) begin
        bit rdy, slot_free, take;
        if (!rst_n) begin
            m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_rs2 = 0; m_rd = 0;
            m_rd_we = 0; m_ld = 0; m_st = 0; m_pc = RST_PC; m_issued = 0; m_stalls = 0;
        end else begin
            rdy = model_ready();
            slot_free = !m_valid || ex_ready;
            take = slot_free && id_valid && !must_wait() && !flush;
            if (id_valid && !rdy && !flush) m_stalls = m_stalls + 1;
            if (take) m_issued = m_issued + 1;
            if (flush) begin
                m_valid = 0;
            end else if (take) begin
                m_valid = 1; m_op = id_alu_op;
                m_a = id_use_pc ? id_pc : value_of(id_rs1, rf_rs1_data);
                m_b = id_use_imm ? id_imm : value_of(id_rs2, rf_rs2_data);
                m_rs2 = value_of(id_rs2, rf_rs2_data);
                m_rd = id_rd; m_rd_we = id_rd_we; m_ld = id_is_load; m_st = id_is_store;
                m_pc = id_pc;
            end else if (slot_free) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("id_ready", {31'd0, id_ready}, {31'd0, model_ready()});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            chk("ex_alu_op", {27'd0, ex_alu_op}, {27'd0, m_op});
            chk("ex_alu_a", ex_alu_a, m_a);
            chk("ex_alu_b", ex_alu_b, m_b);
            chk("ex_rs2_data", ex_rs2_data, m_rs2);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("ex_ctl", {29'd0, ex_rd_we, ex_is_load, ex_is_store},
                {29'd0, m_rd_we, m_ld, m_st});
            chk("ex_pc", ex_pc, m_pc);
`ifdef ISSUE_PERF_EN
            chk("perf_issued", perf_issued, m_issued);
            chk("perf_stalls", perf_stalls, m_stalls);
`else
            chk("perf_issued", perf_issued, 32'd0);
            chk("perf_stalls", perf_stalls, 32'd0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic upc,
                         input logic uimm, input logic ld, input logic st,
                         input logic [31:0] imm, input logic [31:0] pc);
        id_valid = 1; id_alu_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd_we = we; id_use_pc = upc; id_use_imm = uimm; id_is_load = ld;
        id_is_store = st; id_imm = imm; id_pc = pc;
    endtask

    task automatic no_fwd();
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    initial begin
        rst_n = 0; ex_ready = 1; flush = 0;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        no_fwd();
        cyc();
        started = 1;
        cyc();
        chk("rst id_ready", {31'd0, id_ready}, 32'd0);
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst ex_pc", ex_pc, RST_PC);

        rst_n = 1;
        instr(0, 1, 2, 10, 1, 0, 0, 0, 0, 0, 32'h40);
        rf_rs1_data = 5; rf_rs2_data = 7;
        cyc();
        chk("add valid", {31'd0, ex_valid}, 32'd1);
        chk("add a", ex_alu_a, 32'd5);
        chk("add b", ex_alu_b, 32'd7);
        chk("add op", {27'd0, ex_alu_op}, 32'd0);

        // Forwarding priority: MEM over WB over register file.
        instr(4, 3, 2, 11, 1, 0, 0, 0, 0, 0, 32'h44);
        rf_rs1_data = 32'h33;
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h11;
        wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 32'h22;
        cyc();
        chk("fwd mem", ex_alu_a, 32'h11);
        id_rs1 = 0; id_pc = 32'h48;
        cyc();
        chk("fwd x0", ex_alu_a, 32'h0);
        id_rs1 = 3; mem_fwd_valid = 0; id_pc = 32'h4C;
        cyc();
        chk("fwd wb", ex_alu_a, 32'h22);
        no_fwd();

        // Load-use: LW x4 then ADD x5 = x4 + x2.
        instr(0, 1, 0, 4, 1, 0, 1, 1, 0, 8, 32'h50);
        cyc();
        instr(0, 4, 2, 5, 1, 0, 0, 0, 0, 0, 32'h54);
        #1;
        chk("lu id_ready", {31'd0, id_ready}, 32'd0);
        cyc();
        chk("lu bubble", {31'd0, ex_valid}, 32'd0);
        mem_fwd_valid = 1; mem_fwd_rd = 4; mem_fwd_data = 32'hABCD;
        cyc();
        chk("lu issue valid", {31'd0, ex_valid}, 32'd1);
        chk("lu issue a", ex_alu_a, 32'hABCD);
        no_fwd();

        // Back-pressure for three cycles.
        ex_ready = 0;
        instr(4, 1, 2, 6, 1, 0, 0, 0, 0, 0, 32'h58);
        cyc(); cyc(); cyc();
        chk("bp id_ready", {31'd0, id_ready}, 32'd0);
        chk("bp hold a", ex_alu_a, 32'hABCD);
        chk("bp hold pc", ex_pc, 32'h54);
`ifdef ISSUE_PERF_EN
        // One load-use stall plus three back-pressure stalls; six instructions issued.
        chk("bp perf_stalls", perf_stalls, 32'd4);
        chk("bp perf_issued", perf_issued, 32'd6);
`else
        chk("bp perf_stalls", perf_stalls, 32'd0);
`endif

        flush = 1;
        #1;
        chk("flush id_ready", {31'd0, id_ready}, 32'd1);
        cyc();
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        flush = 0; ex_ready = 1;

        instr(8, 1, 6, 7, 1, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h100);
        rf_rs2_data = 32'h66; wb_fwd_valid = 1; wb_fwd_rd = 6; wb_fwd_data = 32'h77;
        cyc();
        chk("sub a", ex_alu_a, 32'h100);
        chk("sub b", ex_alu_b, 32'hFFFF_FFFC);
        chk("sub rs2", ex_rs2_data, 32'h77);
        chk("sub op", {27'd0, ex_alu_op}, 32'd8);
        no_fwd();

        // Store data depends on a load even though B is the immediate.
        instr(0, 0, 0, 7, 1, 0, 1, 1, 0, 4, 32'h104);
        cyc();
        instr(0, 0, 7, 0, 0, 0, 1, 0, 1, 0, 32'h108);
        #1;
        chk("st hazard", {31'd0, id_ready}, 32'd0);
        cyc();
        mem_fwd_valid = 1; mem_fwd_rd = 7; mem_fwd_data = 32'h5A5A;
        cyc();
        chk("st data", ex_rs2_data, 32'h5A5A);
        no_fwd();

        // Load into x0 never stalls; use_pc hides a matching rs1.
        instr(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 32'h10C);
        cyc();
        instr(0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 32'h110);
        cyc();
        instr(0, 0, 0, 9, 1, 0, 1, 1, 0, 0, 32'h114);
        cyc();
        instr(0, 9, 9, 10, 1, 1, 1, 0, 0, 3, 32'h118);
        #1;
        chk("use_pc no hazard", {31'd0, id_ready}, 32'd1);
        cyc();

        // Reset while stalled drops the held instruction.
        ex_ready = 0;
        instr(6, 1, 2, 11, 1, 0, 0, 0, 0, 0, 32'h11C);
        cyc();
        rst_n = 0;
        cyc();
        chk("rst mid ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst mid perf", perf_issued, 32'd0);
        rst_n = 1; ex_ready = 1; id_valid = 0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
